// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch-queue head handshake from IF towards ID
interface if_fetch_queue_if #(
    parameter int ADDR_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_instr;

    modport master (output out_valid, output out_pc, output out_instr, input  out_ready);
    modport slave  (input  out_valid, input  out_pc, input  out_instr, output out_ready);
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction-fetch stage with redirectable DEPTH-entry prefetch queue
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] IRQ_PC   = 32'h8000_0004,
    parameter logic [ADDR_W-1:0] EXC_PC   = 32'h8000_0008
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-2:0]      imem_addr,
    input  logic [ADDR_W-1:0]      imem_rdata,
    input  logic                   irq,
    input  logic                   exc,
    input  logic                   branch_en,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic                   jump_i,
    input  logic [ADDR_W-1:0]      jump_i_target,
    input  logic                   jump_r,
    input  logic [ADDR_W-1:0]      jump_r_target,
    if_fetch_queue_if.master       fetch,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] q_pc    [DEPTH];
    logic [ADDR_W-1:0] q_instr [DEPTH];
    logic              redirect;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] target;

    assign redirect = irq | exc | branch_en | jump_i | jump_r;

    always_comb begin
        target = jump_r_target;
        if (irq)            target = IRQ_PC;
        else if (exc)       target = EXC_PC;
        else if (branch_en) target = branch_target;
        else if (jump_i)    target = jump_i_target;
    end

    // A redirect hides the head in the same cycle, so any pop is void.
    assign fetch.out_valid = (count != '0) & ~redirect;
    assign fetch.out_pc    = q_pc[rd_ptr];
    assign fetch.out_instr = q_instr[rd_ptr];
    assign pop             = fetch.out_valid & fetch.out_ready;
    assign push            = ~redirect & ((count < CW'(DEPTH)) | pop);
    assign imem_addr       = fetch_pc[ADDR_W-2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is deliberately unreset; occupancy alone defines what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized and directed bench for if_fetch_queue with queue-based model
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [30:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        irq = 1'b0, exc = 1'b0, branch_en = 1'b0, jump_i = 1'b0, jump_r = 1'b0;
    logic [31:0] branch_target = '0, jump_i_target = '0, jump_r_target = '0;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic [31:0] rom_key = '0;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc;

    if_fetch_queue_if #(.ADDR_W(32)) ifc ();

    assign ifc.out_ready = out_ready;
    assign imem_rdata    = {1'b0, imem_addr} ^ rom_key;

    if_fetch_queue #(.ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .irq(irq), .exc(exc),
        .branch_en(branch_en), .branch_target(branch_target),
        .jump_i(jump_i), .jump_i_target(jump_i_target),
        .jump_r(jump_r), .jump_r_target(jump_r_target),
        .fetch(ifc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return {1'b0, pc[30:0]} ^ rom_key;
    endfunction

    function automatic logic m_redirect();
        return irq | exc | branch_en | jump_i | jump_r;
    endfunction

    function automatic logic m_valid();
        return (m_q.size() != 0) && !m_redirect();
    endfunction

    function automatic logic [31:0] m_target();
        if (irq) return 32'h8000_0004;
        if (exc) return 32'h8000_0008;
        if (branch_en) return branch_target;
        if (jump_i) return jump_i_target;
        return jump_r_target;
    endfunction

    // Reference behaviour for one clock edge, from the inputs currently applied.
    task automatic model_step();
        bit pop, push;
        if (m_redirect()) begin
            m_q.delete();
            m_pc = m_target();
        end else begin
            pop  = (m_q.size() != 0) && out_ready;
            push = (m_q.size() < 4) || pop;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        irq = 0; exc = 0; branch_en = 0; jump_i = 0; jump_r = 0;
    endtask

    task automatic do_reset();
        clear_redirects();
        out_ready = 0;
        reset = 1;
        m_q.delete();
        m_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset();
        #2 reset = 1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifc.out_valid); end
        checks++; if (imem_addr !== 31'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        m_q.delete();
        m_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_stream();
        out_ready = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, ifc.out_valid); end
            checks++; if (ifc.out_pc !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc i=%0d got=%h exp=%h", i, ifc.out_pc, 4 * i); end
            checks++; if (ifc.out_instr !== 32'(4 * i)) begin failures++; $display("FAIL stream_instr i=%0d got=%h exp=%h", i, ifc.out_instr, 4 * i); end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 0;
        repeat (6) tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", count); end
        checks++; if (imem_addr !== 31'd16) begin failures++; $display("FAIL bp_addr got=%h exp=10", imem_addr); end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, ifc.out_valid); end
            checks++; if (ifc.out_pc !== 32'(4 * i)) begin failures++; $display("FAIL bp_pc i=%0d got=%h exp=%h", i, ifc.out_pc, 4 * i); end
            checks++; if (count !== 3'(m_q.size())) begin failures++; $display("FAIL bp_flow_count i=%0d got=%0d exp=%0d", i, count, m_q.size()); end
            tick();
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] h;
        logic [30:0] p;
        out_ready = 0;
        tick();
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_pre_count got=%0d exp=4", count); end
        h = m_q[0][63:32];
        p = m_pc[30:0];
        out_ready = 1;
        tick();
        out_ready = 0;
        #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        checks++; if (ifc.out_pc !== h + 32'd4) begin failures++; $display("FAIL fullpop_head got=%h exp=%h", ifc.out_pc, h + 32'd4); end
        checks++; if (imem_addr !== p + 31'd4) begin failures++; $display("FAIL fullpop_addr got=%h exp=%h", imem_addr, p + 31'd4); end
    endtask

    task automatic test_branch();
        do_reset();
        out_ready = 1;
        repeat (3) tick();
        branch_en = 1; branch_target = 32'h100;
        #1;
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL branch_valid_now got=%b exp=0", ifc.out_valid); end
        tick();
        clear_redirects();
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL branch_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 31'h100) begin failures++; $display("FAIL branch_addr got=%h exp=100", imem_addr); end
        tick();
        checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h100) begin failures++; $display("FAIL branch_head got=%b/%h exp=1/100", ifc.out_valid, ifc.out_pc); end
        tick();
        checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h104) begin failures++; $display("FAIL branch_next got=%b/%h exp=1/104", ifc.out_valid, ifc.out_pc); end
    endtask

    task automatic test_priority();
        logic [4:0]  combo [3];
        logic [31:0] exp_pc;
        combo[0] = 5'b11101;  // irq exc branch_en - jump_r
        combo[1] = 5'b01010;  // exc jump_i
        combo[2] = 5'b00011;  // jump_i jump_r
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_i_target = $urandom & 32'hFFFF_FFFC;
            jump_r_target = $urandom & 32'hFFFF_FFFC;
            {irq, exc, branch_en, jump_i, jump_r} = combo[k];
            exp_pc = (k == 0) ? 32'h8000_0004 : (k == 1) ? 32'h8000_0008 : jump_i_target;
            #1;
            checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL prio_valid k=%0d got=%b exp=0", k, ifc.out_valid); end
            tick();
            clear_redirects();
            tick();
            checks++; if (ifc.out_pc !== exp_pc) begin failures++; $display("FAIL prio_head k=%0d got=%h exp=%h", k, ifc.out_pc, exp_pc); end
            checks++; if (ifc.out_instr !== rom(exp_pc)) begin failures++; $display("FAIL prio_instr k=%0d got=%h exp=%h", k, ifc.out_instr, rom(exp_pc)); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
        out_ready = 1;
        jump_i = 1; jump_i_target = 32'hFFFF_FFF8;
        tick();
        clear_redirects();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc i=%0d got=%b/%h exp=1/%h", i, ifc.out_valid, ifc.out_pc, exp_pc[i]); end
            checks++; if (ifc.out_instr !== rom(exp_pc[i])) begin failures++; $display("FAIL wrap_instr i=%0d got=%h exp=%h", i, ifc.out_instr, rom(exp_pc[i])); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        jump_r = 1; jump_r_target = 32'h1F4;
        tick();
        clear_redirects();
        repeat (3) tick();
        checks++; if (count !== 3'd3 || imem_addr !== 31'h200) begin failures++; $display("FAIL areset_pre got=%0d/%h exp=3/200", count, imem_addr); end
        #3 reset = 1;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
        checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", ifc.out_valid); end
        checks++; if (imem_addr !== 31'd0) begin failures++; $display("FAIL areset_addr got=%h exp=0", imem_addr); end
        #2 reset = 0;
        m_q.delete();
        m_pc = 32'h0;
        out_ready = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'(4 * i)) begin failures++; $display("FAIL areset_stream i=%0d got=%b/%h exp=1/%h", i, ifc.out_valid, ifc.out_pc, 4 * i); end
            tick();
        end
    endtask

    task automatic test_random();
        int r;
        rom_key = $urandom;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            clear_redirects();
            if (r == 0) begin
                branch_target = $urandom & 32'hFFFF_FFFC;
                jump_i_target = $urandom & 32'hFFFF_FFFC;
                jump_r_target = $urandom & 32'hFFFF_FFFC;
                {irq, exc, branch_en, jump_i, jump_r} = 5'($urandom_range(1, 31));
            end
            #1;
            checks++; if (ifc.out_valid !== m_valid()) begin failures++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, ifc.out_valid, m_valid()); end
            checks++; if (count !== 3'(m_q.size())) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, m_q.size()); end
            checks++; if (imem_addr !== m_pc[30:0]) begin failures++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, imem_addr, m_pc[30:0]); end
            if (m_valid()) begin
                checks++; if ({ifc.out_pc, ifc.out_instr} !== m_q[0]) begin failures++; $display("FAIL rand_head i=%0d got=%h/%h exp=%h/%h", i, ifc.out_pc, ifc.out_instr, m_q[0][63:32], m_q[0][31:0]); end
            end
            tick();
        end
        clear_redirects();
        rom_key = '0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_full_pop();
        test_branch();
        test_priority();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
